// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl - sprite DMA controller and CPU bus arbiter.
// A CPU write to DMA_REG with page P takes over the shared CPU bus. The block
// stalls the CPU and copies $P00-$PFF into OAM_PORT as alternating read and
// write cycles. Outside a transfer the CPU bus passes straight through.
// Optional feature macro: OAM_DMA_ODD_ALIGN_EN. When defined, a free-running
// parity bit inserts one ALIGN cycle if the HALT cycle falls on odd parity.
//
// Handshake: cpu_rdy=1 means the CPU may complete its current bus cycle on the
// next rising edge. cpu_rdy=0 means the CPU must hold that cycle unchanged.
// cpu_rdy is decoded from the state register, so it drops in the cycle after
// the trigger edge and rises in the cycle after the last OAM write.
module oam_dma_ctrl #(
   parameter logic [15:0] DMA_REG  = 16'h4014,
   parameter logic [15:0] OAM_PORT = 16'h2004
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_en,
   input  logic        cpu_write,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_dout,
   output logic        cpu_rdy,
   output logic        bus_en,
   output logic        bus_write,
   output logic [15:0] bus_addr,
   output logic [7:0]  bus_dout,
   input  logic [7:0]  bus_din,
   output logic        dma_busy
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_HALT  = 3'd1,
      S_ALIGN = 3'd2,
      S_READ  = 3'd3,
      S_WRITE = 3'd4
   } state_t;

   state_t     r_state;
   logic [7:0] r_page;
   logic [7:0] r_idx;
   logic       w_trigger;
   logic       w_align;

   assign w_trigger = cpu_en & cpu_write & (cpu_addr == DMA_REG);

`ifdef OAM_DMA_ODD_ALIGN_EN
   logic r_parity;

   // Free-running parity; models the 2A03 get/put cycle phase
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_parity <= 1'b0;
      end else begin
         r_parity <= ~r_parity;
      end
   end

   assign w_align = r_parity;
`else
   // Without the alignment feature the ALIGN state is never entered
   assign w_align = 1'b0;
`endif

   // Transfer sequencer: trigger, halt, optional align, then 256 read/write pairs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_page  <= 8'd0;
         r_idx   <= 8'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_trigger) begin
                  r_page  <= cpu_dout;
                  r_idx   <= 8'd0;
                  r_state <= S_HALT;
               end
            end
            S_HALT: begin
               r_state <= w_align ? S_ALIGN : S_READ;
            end
            S_ALIGN: begin
               r_state <= S_READ;
            end
            S_READ: begin
               r_state <= S_WRITE;
            end
            S_WRITE: begin
               // idx wraps 255->0 on the last byte, leaving it clean for the next run
               r_idx <= r_idx + 8'd1;
               if (r_idx == 8'hFF) begin
                  r_state <= S_IDLE;
               end else begin
                  r_state <= S_READ;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Bus mux: pass-through in IDLE, DMA cycles otherwise. bus_din feeds the
   // write combinationally because it returns the data of the preceding READ.
   always_comb begin
      cpu_rdy   = 1'b0;
      dma_busy  = 1'b1;
      bus_en    = 1'b0;
      bus_write = 1'b0;
      bus_addr  = 16'h0000;
      bus_dout  = 8'h00;
      case (r_state)
         S_IDLE: begin
            cpu_rdy   = 1'b1;
            dma_busy  = 1'b0;
            bus_en    = cpu_en;
            bus_write = cpu_write;
            bus_addr  = cpu_addr;
            bus_dout  = cpu_dout;
         end
         S_READ: begin
            bus_en    = 1'b1;
            bus_addr  = {r_page, r_idx};
         end
         S_WRITE: begin
            bus_en    = 1'b1;
            bus_write = 1'b1;
            bus_addr  = OAM_PORT;
            bus_dout  = bus_din;
         end
         default: begin
            // HALT and ALIGN leave the bus idle
         end
      endcase
   end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb_oam_dma_ctrl - directed bench for oam_dma_ctrl with a 64 KB bus model.
// Build with +define+OAM_DMA_ODD_ALIGN_EN to exercise the alignment feature.
module tb_oam_dma_ctrl;

   logic        clk;
   logic        reset;
   logic        cpu_en;
   logic        cpu_write;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_dout;
   logic        cpu_rdy;
   logic        bus_en;
   logic        bus_write;
   logic [15:0] bus_addr;
   logic [7:0]  bus_dout;
   logic [7:0]  bus_din;
   logic        dma_busy;

   int n_cmp = 0;
   int n_err = 0;

   // bus model and transfer logs
   logic [7:0]  mem [0:65535];
   logic        rd_pend = 1'b0;
   logic [15:0] rd_addr = 16'h0000;
   logic [7:0]  oam_q [$];
   logic [15:0] rd_q [$];
   int          busy_cnt = 0;
   logic        tp;
   logic        halt_par = 1'b0;

   oam_dma_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_en    (cpu_en),
      .cpu_write (cpu_write),
      .cpu_addr  (cpu_addr),
      .cpu_dout  (cpu_dout),
      .cpu_rdy   (cpu_rdy),
      .bus_en    (bus_en),
      .bus_write (bus_write),
      .bus_addr  (bus_addr),
      .bus_dout  (bus_dout),
      .bus_din   (bus_din),
      .dma_busy  (dma_busy)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference parity phase: 0 out of reset, toggles every edge
   always @(posedge clk or negedge reset) begin
      if (!reset) tp <= 1'b0;
      else        tp <= ~tp;
   end

   // bus monitor and memory: sample mid-cycle, return read data next cycle
   always @(negedge clk) begin
      if (bus_en && bus_write) begin
         mem[bus_addr] = bus_dout;
         if (dma_busy && bus_addr == 16'h2004) oam_q.push_back(bus_dout);
      end
      if (bus_en && !bus_write) begin
         rd_pend = 1'b1;
         rd_addr = bus_addr;
         if (dma_busy) rd_q.push_back(bus_addr);
      end else begin
         rd_pend = 1'b0;
      end
      if (!cpu_rdy && reset) begin
         if (busy_cnt == 0) halt_par = tp;
         busy_cnt++;
      end
   end

   always @(posedge clk) begin
      if (rd_pend) bus_din <= mem[rd_addr];
   end

   // ---------------- driver tasks ----------------
   task automatic cpu_idle();
      cpu_en = 1'b0; cpu_write = 1'b0; cpu_addr = 16'h0000; cpu_dout = 8'h00;
   endtask

   task automatic clear_logs();
      oam_q.delete();
      rd_q.delete();
      busy_cnt = 0;
   endtask

   task automatic trigger(input logic [7:0] page);
      @(posedge clk); #2;
      cpu_en = 1'b1; cpu_write = 1'b1; cpu_addr = 16'h4014; cpu_dout = page;
      @(posedge clk); #2;
      cpu_idle();
   endtask

   // trigger and wait for completion; optionally issue a stray $4014 write mid-run
   task automatic run_dma(input logic [7:0] page, input bit stray, output int len);
      bit done;
      done = 1'b0;
      clear_logs();
      trigger(page);
      for (int c = 0; c < 1200; c++) begin
         @(posedge clk); #2;
         if (stray && c == 40) begin
            cpu_en = 1'b1; cpu_write = 1'b1; cpu_addr = 16'h4014; cpu_dout = 8'h03;
         end else if (stray && c == 41) begin
            cpu_idle();
         end
         if (busy_cnt > 0 && cpu_rdy) begin
            done = 1'b1;
            break;
         end
      end
      n_cmp++;
      if (!done) begin
         n_err++;
         $display("FAIL dma_timeout: transfer of page %02h still busy after 1200 cycles", page);
      end
      len = busy_cnt;
   endtask

   task automatic preload(input logic [7:0] page, input bit pattern_b);
      for (int i = 0; i < 256; i++) begin
         logic [7:0] b;
         b = i[7:0];
         mem[{page, b}] = pattern_b ? (b * 8'd7 + 8'd3) : (b ^ 8'h5A);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b0;
      cpu_en = 1'b1; cpu_write = 1'b0; cpu_addr = 16'hABCD; cpu_dout = 8'h55;
      #1;
      n_cmp++;
      if (cpu_rdy !== 1'b1 || dma_busy !== 1'b0 || bus_en !== 1'b1 ||
          bus_write !== 1'b0 || bus_addr !== 16'hABCD || bus_dout !== 8'h55) begin
         n_err++;
         $display("FAIL reset_passthru: rdy=%b busy=%b en=%b wr=%b addr=%h dout=%h required 1 0 1 0 abcd 55",
                  cpu_rdy, dma_busy, bus_en, bus_write, bus_addr, bus_dout);
      end
      repeat (2) @(posedge clk);
      #2;
      cpu_idle();
      reset = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (cpu_rdy !== 1'b1 || dma_busy !== 1'b0 || bus_en !== 1'b0) begin
         n_err++;
         $display("FAIL reset_idle: rdy=%b busy=%b en=%b required 1 0 0", cpu_rdy, dma_busy, bus_en);
      end
   endtask

   task automatic test_idle_passthru();
      mem[16'h8000] = 8'hC3;
      @(posedge clk); #2;
      cpu_en = 1'b1; cpu_write = 1'b0; cpu_addr = 16'h8000;
      #1;
      n_cmp++;
      if (bus_addr !== 16'h8000 || bus_en !== 1'b1 || bus_write !== 1'b0 ||
          cpu_rdy !== 1'b1 || dma_busy !== 1'b0) begin
         n_err++;
         $display("FAIL idle_read: addr=%h en=%b wr=%b rdy=%b busy=%b required 8000 1 0 1 0",
                  bus_addr, bus_en, bus_write, cpu_rdy, dma_busy);
      end
      @(posedge clk); #2;
      cpu_en = 1'b1; cpu_write = 1'b1; cpu_addr = 16'h0010; cpu_dout = 8'h77;
      n_cmp++;
      if (bus_din !== 8'hC3) begin
         n_err++;
         $display("FAIL idle_read_data: got %h required c3", bus_din);
      end
      #1;
      n_cmp++;
      if (bus_dout !== 8'h77 || bus_write !== 1'b1 || bus_addr !== 16'h0010) begin
         n_err++;
         $display("FAIL idle_write: dout=%h wr=%b addr=%h required 77 1 0010", bus_dout, bus_write, bus_addr);
      end
      @(posedge clk); #2;
      cpu_idle();
      n_cmp++;
      if (mem[16'h0010] !== 8'h77) begin
         n_err++;
         $display("FAIL idle_write_mem: got %h required 77", mem[16'h0010]);
      end
   endtask

   task automatic test_transfer();
      int len;
      int exp_len;
      preload(8'h02, 1'b0);
      run_dma(8'h02, 1'b0, len);
      exp_len = 513;
`ifdef OAM_DMA_ODD_ALIGN_EN
      exp_len = 513 + int'(halt_par);
`endif
      n_cmp++;
      if (len != exp_len) begin
         n_err++;
         $display("FAIL xfer_len: busy %0d cycles required %0d", len, exp_len);
      end
      n_cmp++;
      if (oam_q.size() != 256 || rd_q.size() != 256) begin
         n_err++;
         $display("FAIL xfer_count: oam=%0d rd=%0d required 256", oam_q.size(), rd_q.size());
      end
      for (int i = 0; i < 256 && i < oam_q.size() && i < rd_q.size(); i++) begin
         logic [7:0] b;
         b = i[7:0];
         n_cmp++;
         if (oam_q[i] !== (b ^ 8'h5A) || rd_q[i] !== {8'h02, b}) begin
            n_err++;
            $display("FAIL xfer_byte[%0d]: data=%h src=%h required %h %h",
                     i, oam_q[i], rd_q[i], b ^ 8'h5A, {8'h02, b});
         end
      end
   endtask

   task automatic test_second_write_ignored();
      int len;
      int exp_len;
      preload(8'h02, 1'b0);
      preload(8'h03, 1'b1);
      run_dma(8'h02, 1'b1, len);
      exp_len = 513;
`ifdef OAM_DMA_ODD_ALIGN_EN
      exp_len = 513 + int'(halt_par);
`endif
      n_cmp++;
      if (len != exp_len) begin
         n_err++;
         $display("FAIL stray_len: busy %0d cycles required %0d", len, exp_len);
      end
      n_cmp++;
      if (oam_q.size() != 256 || rd_q.size() != 256) begin
         n_err++;
         $display("FAIL stray_count: oam=%0d rd=%0d required 256", oam_q.size(), rd_q.size());
      end
      for (int i = 0; i < 256 && i < oam_q.size() && i < rd_q.size(); i++) begin
         logic [7:0] b;
         b = i[7:0];
         n_cmp++;
         if (oam_q[i] !== (b ^ 8'h5A) || rd_q[i] !== {8'h02, b}) begin
            n_err++;
            $display("FAIL stray_byte[%0d]: data=%h src=%h required %h %h",
                     i, oam_q[i], rd_q[i], b ^ 8'h5A, {8'h02, b});
         end
      end
   endtask

   task automatic test_reset_mid_transfer();
      int len;
      bit reached;
      preload(8'h02, 1'b0);
      clear_logs();
      trigger(8'h02);
      reached = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(posedge clk);
         if (oam_q.size() == 100) begin
            reached = 1'b1;
            break;
         end
      end
      n_cmp++;
      if (!reached) begin
         n_err++;
         $display("FAIL abort_reach: only %0d bytes written, required 100", oam_q.size());
      end
      #3;
      cpu_en = 1'b1; cpu_write = 1'b0; cpu_addr = 16'h1234;
      reset = 1'b0;
      #1;
      n_cmp++;
      if (cpu_rdy !== 1'b1 || dma_busy !== 1'b0 || bus_en !== 1'b1 ||
          bus_write !== 1'b0 || bus_addr !== 16'h1234) begin
         n_err++;
         $display("FAIL abort_passthru: rdy=%b busy=%b en=%b wr=%b addr=%h required 1 0 1 0 1234",
                  cpu_rdy, dma_busy, bus_en, bus_write, bus_addr);
      end
      @(posedge clk); #2;
      cpu_idle();
      reset = 1'b1;
      run_dma(8'h02, 1'b0, len);
      n_cmp++;
      if (oam_q.size() != 256 || rd_q.size() != 256) begin
         n_err++;
         $display("FAIL restart_count: oam=%0d rd=%0d required 256", oam_q.size(), rd_q.size());
      end
      for (int i = 0; i < 256 && i < oam_q.size() && i < rd_q.size(); i++) begin
         logic [7:0] b;
         b = i[7:0];
         n_cmp++;
         if (oam_q[i] !== (b ^ 8'h5A) || rd_q[i] !== {8'h02, b}) begin
            n_err++;
            $display("FAIL restart_byte[%0d]: data=%h src=%h required %h %h",
                     i, oam_q[i], rd_q[i], b ^ 8'h5A, {8'h02, b});
         end
      end
   endtask

   task automatic test_page_ff();
      int len;
      preload(8'hFF, 1'b1);
      run_dma(8'hFF, 1'b0, len);
      n_cmp++;
      if (oam_q.size() != 256 || rd_q.size() != 256) begin
         n_err++;
         $display("FAIL ff_count: oam=%0d rd=%0d required 256", oam_q.size(), rd_q.size());
      end
      for (int i = 0; i < 256 && i < oam_q.size() && i < rd_q.size(); i++) begin
         logic [7:0] b;
         b = i[7:0];
         n_cmp++;
         if (oam_q[i] !== (b * 8'd7 + 8'd3) || rd_q[i] !== {8'hFF, b}) begin
            n_err++;
            $display("FAIL ff_byte[%0d]: data=%h src=%h required %h %h",
                     i, oam_q[i], rd_q[i], b * 8'd7 + 8'd3, {8'hFF, b});
         end
      end
      // CPU held idle afterwards: no further bus access, in particular none at $0000
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         n_cmp++;
         if (bus_en !== 1'b0 || cpu_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL ff_after[%0d]: en=%b addr=%h rdy=%b required 0 - 1", c, bus_en, bus_addr, cpu_rdy);
         end
      end
   endtask

`ifdef OAM_DMA_ODD_ALIGN_EN
   task automatic test_align();
      int len_a, len_b;
      logic par_a, par_b;
      preload(8'h02, 1'b0);
      for (int k = 2; k <= 3; k++) begin
         @(posedge clk); #2;
         reset = 1'b0;
         @(posedge clk); #2;
         reset = 1'b1;
         repeat (k) @(posedge clk);
         if (k == 2) begin
            run_dma(8'h02, 1'b0, len_a);
            par_a = halt_par;
         end else begin
            run_dma(8'h02, 1'b0, len_b);
            par_b = halt_par;
         end
      end
      n_cmp++;
      if (len_a != 513 + int'(par_a) || len_b != 513 + int'(par_b) || par_a == par_b) begin
         n_err++;
         $display("FAIL align_len: lens %0d/%0d parity %b/%b required 513+parity with differing parity",
                  len_a, len_b, par_a, par_b);
      end
      n_cmp++;
      if (len_a + len_b != 1027) begin
         n_err++;
         $display("FAIL align_pair: lens %0d+%0d required sum 1027", len_a, len_b);
      end
   endtask
`endif

   initial begin
      for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
      bus_din = 8'h00;
      cpu_idle();
      test_reset();
      test_idle_passthru();
      test_transfer();
      test_second_write_ignored();
      test_reset_mid_transfer();
      test_page_ff();
`ifdef OAM_DMA_ODD_ALIGN_EN
      test_align();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/oam_dma_ctrl.md
# oam_dma_ctrl

Sprite-DMA controller and CPU-bus arbiter for the NES top level. A CPU write to $4014 with page value P hands the shared CPU bus (PRAM/PROM/PPU register decode) to this block. It stalls the CPU and copies the 256 bytes at $P00–$PFF into the PPU OAM data port $2004, as alternating read and write bus cycles. Outside a transfer it passes CPU bus signals through unchanged.

## Interface
Parameters:
- DMA_REG, 16'h4014, CPU address that triggers a transfer
- OAM_PORT, 16'h2004, destination address written for every byte

Ports:
- clk  input  1  system clock, rising edge; the same clock as the CPU bus
- reset  input  1  asynchronous, active-low; forces IDLE immediately
- cpu_en  input  1  CPU bus enable
- cpu_write  input  1  CPU write strobe
- cpu_addr  input  16  CPU address
- cpu_dout  input  8  CPU write data
- cpu_rdy  output  1  1 = CPU may advance; 0 = CPU must hold its current cycle
- bus_en  output  1  enable to the address decode and memories
- bus_write  output  1  write strobe to the decode and memories
- bus_addr  output  16  address to the decode and memories
- bus_dout  output  8  write data to the decode and memories
- bus_din  input  8  read data from the decode mux; valid the cycle after the read address is presented
- dma_busy  output  1  high while the controller owns the bus

## Operation
- States: IDLE, HALT, ALIGN, READ, WRITE.
- IDLE:
  - bus_en/bus_write/bus_addr/bus_dout equal cpu_en/cpu_write/cpu_addr/cpu_dout, combinationally.
  - cpu_rdy=1, dma_busy=0.
  - When cpu_en & cpu_write & cpu_addr==DMA_REG at a clk edge: latch page<=cpu_dout, idx<=0, go to HALT.
  - The trigger write itself passes through to the bus.
- HALT: one cycle, bus idle. Next state is ALIGN if the ALIGN condition holds (see Configuration); otherwise READ.
- ALIGN: one cycle, bus idle, then READ.
- READ: bus_en=1, bus_write=0, bus_addr={page,idx}. Next state is WRITE.
- WRITE:
  - bus_en=1, bus_write=1, bus_addr=OAM_PORT, bus_dout=bus_din. bus_din is sampled combinationally; it is the data for the preceding READ.
  - If idx==8'hFF, go to IDLE. Otherwise idx<=idx+1 and go to READ.
- Bus idle means bus_en=0, bus_write=0, bus_addr=0, bus_dout=0.
- In every non-IDLE state: cpu_rdy=0 and dma_busy=1. All CPU inputs are ignored, including a second $4014 write.
- idx is 8 bits. The transfer ends on the 255 to 0 wrap, so exactly 256 bytes are copied. page=$FF reads $FF00–$FFFF (PROM) and is legal.
- Reset at any time, including mid-transfer: state=IDLE, page=0, idx=0, parity=0. Outputs revert to pass-through; cpu_rdy=1, dma_busy=0. The partial transfer is abandoned and is not resumed.

## Timing
- The trigger edge is T0. HALT occupies cycle T0+1; cpu_rdy falls in that cycle (state-decoded, no extra register).
- Without ALIGN, the first READ is at T0+2.
- Each byte takes 2 cycles. The last WRITE is at T0+513; IDLE and cpu_rdy=1 at T0+514.
- Busy length: 513 cycles, or 514 with ALIGN.
- Read-to-write latency is fixed at 1 cycle. bus_din must be stable in the cycle following READ; block-RAM sources on clk satisfy this.
- Outputs with reset asserted: pass-through of CPU inputs, cpu_rdy=1, dma_busy=0.

## Configuration
- OAM_DMA_ODD_ALIGN_EN defined:
  - A 1-bit parity register toggles every clk; reset value 0.
  - If parity==1 in HALT, one ALIGN cycle is inserted. This gives 514 busy cycles and matches 2A03 odd-cycle behaviour.
- Undefined:
  - No parity register, and the ALIGN state is unreachable.
  - The transfer is always 513 cycles.

## Test plan
- Reset then idle: CPU read at $8000 → bus_addr=$8000, bus_en=1, cpu_rdy=1, dma_busy=0. Through a full bus model, data is unchanged.
- Write $02 to $4014, with PRAM $0200+i preloaded with i^8'h5A:
  - 256 writes to $2004 carry i^8'h5A in order.
  - cpu_rdy=0 for exactly 513 cycles; 514 with the macro and odd start parity.
- Macro defined: trigger once on an even-parity cycle and once on an odd-parity cycle → busy length 513 and 514 respectively.
- Second write to $4014 (value $03) during busy → ignored; all 256 source addresses are $02xx, and the length is unchanged.
- Reset asserted at byte 100 of a transfer → outputs return to pass-through asynchronously, cpu_rdy=1. A new $4014 write restarts from idx=0.
- Page $FF with PROM $FF00–$FFFF loaded:
  - Reads wrap idx FF→00 and the transfer terminates.
  - There is no access to $0000 after the last byte.
